// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and types for the 800x480 parallel-RGB panel.
// Default geometry, derived totals, sync windows and counter widths.
package lcd_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FRONT  = 40;
  localparam int unsigned DEF_H_SYNC   = 48;
  localparam int unsigned DEF_H_BACK   = 40;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 13;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BACK   = 29;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  function automatic int unsigned axis_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned syn,
    input int unsigned bp
  );
    return act + fp + syn + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(
    DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL = axis_total(
    DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

endpackage

// File: rtl/lcd_axis_counter.sv
// One timing axis: position counter with active-area and sync-window decode.
// Used once per line (pixels) and once per frame (lines).
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FRONT  = DEF_H_FRONT,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BACK   = DEF_H_BACK
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output cnt_t count,
  output logic wrap,
  output logic active,
  output logic sync
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT_END = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_LO = cnt_t'(ACTIVE + FRONT);
  localparam cnt_t SYNC_HI = cnt_t'(ACTIVE + FRONT + SYNC);
  localparam cnt_t ONE     = cnt_t'(1);

  cnt_t count_q;
  cnt_t count_d;

  always_comb begin
    wrap    = advance && (count_q == LAST);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (advance) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign active = (count_q < ACT_END);
  assign sync   = (count_q >= SYNC_LO) && (count_q < SYNC_HI);

endmodule

// File: rtl/lcd_timing.sv
// Panel timing generator: pixel-rate pacing for the streamer and
// registered RGB, DE and active-low syncs with one-pixel latency.
module lcd_timing
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        lcd_tick,
  output logic        lcd_next_frame,
  output logic        lcd_data_enable,
  input  logic [7:0]  lcd_red,
  input  logic [7:0]  lcd_green,
  input  logic [7:0]  lcd_blue,
  output logic        panel_clock,
  output logic        panel_hsync,
  output logic        panel_vsync,
  output logic        panel_de,
  output logic [7:0]  panel_red,
  output logic [7:0]  panel_green,
  output logic [7:0]  panel_blue,
  output logic [31:0] frame_count
);

  localparam int unsigned H_TOTAL = axis_total(
    H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(
    V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam cnt_t V_LAST_ACT = cnt_t'(V_ACTIVE - 1);

  if (H_TOTAL > CNT_MAX) begin : g_h_chk
    $error("lcd_timing: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_MAX) begin : g_v_chk
    $error("lcd_timing: V_TOTAL exceeds counter range");
  end

  logic        phase_q, phase_d;
  logic        pclk_q, pclk_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  rgb_t        rgb_q, rgb_d;
  logic [31:0] fc_q, fc_d;

  cnt_t h_count, v_count;
  logic h_wrap, v_wrap;
  logic h_act, v_act;
  logic h_sync, v_sync;
  logic clear;

  assign clear    = ~enable;
  assign lcd_tick = phase_q & enable & ~reset;

  lcd_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (lcd_tick),
    .count   (h_count),
    .wrap    (h_wrap),
    .active  (h_act),
    .sync    (h_sync)
  );

  lcd_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (h_wrap),
    .count   (v_count),
    .wrap    (v_wrap),
    .active  (v_act),
    .sync    (v_sync)
  );

  assign lcd_data_enable = h_act & v_act;
  // v is about to become V_ACTIVE: upstream gets the whole blanking to refill
  assign lcd_next_frame  = h_wrap && (v_count == V_LAST_ACT);

  always_comb begin
    phase_d = enable ? ~phase_q : 1'b0;
    pclk_d  = enable ? phase_q : 1'b0;
    fc_d    = fc_q + 32'(v_wrap);
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    rgb_d   = rgb_q;
    if (!enable) begin
      de_d  = 1'b0;
      hs_d  = 1'b1;
      vs_d  = 1'b1;
      rgb_d = '0;
    end else if (lcd_tick) begin
      de_d  = lcd_data_enable;
      hs_d  = ~h_sync;
      vs_d  = ~v_sync;
      rgb_d = lcd_data_enable ?
              rgb_t'({lcd_red, lcd_green, lcd_blue}) : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b0;
      pclk_q  <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
      fc_q    <= '0;
    end else begin
      phase_q <= phase_d;
      pclk_q  <= pclk_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      fc_q    <= fc_d;
    end
  end

  assign panel_clock = pclk_q;
  assign panel_de    = de_q;
  assign panel_hsync = hs_q;
  assign panel_vsync = vs_q;
  assign panel_red   = rgb_q.red;
  assign panel_green = rgb_q.green;
  assign panel_blue  = rgb_q.blue;
  assign frame_count = fc_q;

endmodule

// File: doc/lcd_timing.md
Name: lcd_timing

Overview:
- Downstream neighbour of the frame-buffer streamer. Generates panel timing for an 800x480 parallel-RGB LCD from the 50 MHz system clock, with a pixel clock of clock/2.
- Drives the streamer's pacing inputs (lcd_tick, lcd_next_frame, lcd_data_enable) and consumes its RGB outputs.
- Registers pixels, syncs and DE to the panel pins with matched one-pixel latency.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 48, hsync width (pixels)
- H_BACK, 40, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 13, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BACK, 29, vertical back porch (lines)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  timing runs when high; when low, panel blanked and counters held at zero
- lcd_tick  out  1  high on one clock of every two; marks a pixel-clock edge
- lcd_next_frame  out  1  one-clock pulse on the tick that enters line V_ACTIVE (start of vertical blanking)
- lcd_data_enable  out  1  high while the current (h,v) position is inside the active area
- lcd_red, lcd_green, lcd_blue  in  8 each  pixel from the upstream streamer
- panel_clock  out  1  pixel clock to the panel pin
- panel_hsync, panel_vsync  out  1  active-low syncs
- panel_de  out  1  registered data enable
- panel_red, panel_green, panel_blue  out  8 each  registered pixel
- frame_count  out  32  debug count of completed frames; wraps

Behaviour:
- Reset: phase=0, h=0, v=0, all panel outputs 0 except hsync/vsync=1; lcd_tick=0, lcd_next_frame=0, frame_count=0.
- Phase bit toggles every clock while enable=1. lcd_tick = phase (combinational). panel_clock = registered phase, so the panel rising edge falls mid-pixel.
- Counters advance only on lcd_tick clocks:
  - h: 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (928).
  - On h wrap, v advances: 0..V_TOTAL-1, where V_TOTAL = 525.
  - On v wrap, frame_count increments.
- lcd_data_enable = (h < H_ACTIVE) && (v < V_ACTIVE), combinational from the counters. It is stable across the non-tick clock before each tick, which lets upstream prefetch one clock early.
- lcd_next_frame:
  - Asserted for exactly one clock: the tick clock on which h wraps and v becomes V_ACTIVE.
  - This leaves 45 blanking lines for the upstream stage to flush and refill.
  - Never asserted while enable=0.
- Sync windows, computed from pre-increment counters:
  - hsync active when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync likewise, using the V parameters.
- Panel registers load only on tick clocks:
  - panel_de <= lcd_data_enable.
  - panel_rgb <= lcd_data_enable ? upstream rgb : 0.
  - syncs loaded from their windows.
  - Latency: one pixel (2 clocks); DE, syncs and RGB stay aligned.
- enable low:
  - phase, h, v forced to 0 synchronously; lcd_tick=0.
  - Panel outputs return to their reset values on the next clock.
  - frame_count holds.
- enable rising: the first tick occurs on the second clock after enable=1; timing restarts at (0,0).
- Reset during operation: every state returns to its reset value on the next clock edge; no partial pulse on lcd_next_frame.
- Counter widths: h 10 bits, v 10 bits. Elaboration asserts H_TOTAL <= 1024 and V_TOTAL <= 1024.

Decomposition:
- Shared package lcd_timing_pkg holds:
  - default panel timing constants;
  - derived H_TOTAL/V_TOTAL and the sync start/end localparams;
  - counter-width constants.
- One natural sub-module, lcd_axis_counter, instantiated twice (horizontal and vertical):
  - inputs: clock, reset, clear, advance;
  - outputs: count, wrap, active, sync;
  - parameterised by active, front, sync and back.

Test Plan:
- Reset released, enable=1 -> lcd_tick toggles 0,1,0,1 from the first clock; one line = 1856 clocks; one frame = 974400 clocks.
- Run 2 frames -> lcd_next_frame pulses exactly twice, 974400 clocks apart, each time when v becomes 480 and h=0; frame_count=2 after the second v wrap.
- Count lcd_data_enable=1 tick clocks over one frame -> exactly 384000.
- Upstream drives rgb=0x112233 only when h=5, v=7 -> panel_red=0x11, green=0x22, blue=0x33 with panel_de=1 exactly one tick later; rgb=0 with panel_de=0 in blanking.
- Check hsync -> low for 48 ticks starting at h=840; vsync low for lines 493..495.
- enable dropped mid-line at h=300 -> next clock h=v=0, lcd_tick=0, panel outputs at reset values; on re-enable timing restarts at (0,0) with no lcd_next_frame pulse during the drop.
